// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: EX->MEM pipeline register for the 5-stage datapath.
//
// Carries PC+4, ALU zero flag, ALU result, store data, destination register and
// MEM/WB control bits from EX to MEM. It uses a valid/ready handshake with a
// two-entry (OUT + SKID) buffer, so in_ready is a pure register output. Latency
// is one cycle and throughput is one transaction per cycle.
//
// Ports
//   clk, rst_n             rising-edge clock, synchronous active-low reset
//   flush                  drop every held and incoming entry (branch mispredict)
//   in_valid / in_ready    EX-side handshake
//   in_*                   EX payload (pc_added, zero, alu_result, write_data, rd, ctrl)
//   out_valid / out_ready  MEM-side handshake (out_ready=0 stalls)
//   out_*                  MEM payload; out_ctrl is forced to 0 whenever out_valid=0
//   stall_cnt              saturating count of cycles with out_valid && !out_ready
module ex_mem_stage_reg #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CTRL_W     = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_pc_added,
    input  logic                  in_zero,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_write_data,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [CTRL_W-1:0]     in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_pc_added,
    output logic                  out_zero,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic [DATA_W-1:0]     out_write_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [CNT_W-1:0]      stall_cnt
);

    // Payload packing: {pc_added, zero, alu_result, write_data, rd, ctrl}
    localparam int unsigned PAY_W    = 3 * DATA_W + REG_ADDR_W + CTRL_W + 1;
    localparam int unsigned CTRL_LSB = 0;
    localparam int unsigned RD_LSB   = CTRL_LSB + CTRL_W;
    localparam int unsigned WD_LSB   = RD_LSB + REG_ADDR_W;
    localparam int unsigned ALU_LSB  = WD_LSB + DATA_W;
    localparam int unsigned ZERO_LSB = ALU_LSB + DATA_W;
    localparam int unsigned PC_LSB   = ZERO_LSB + 1;

    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] out_pay_q, out_pay_d;
    logic [PAY_W-1:0] skid_pay_q, skid_pay_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic accept;
    logic out_free;

    assign in_pay = {in_pc_added, in_zero, in_alu_result, in_write_data, in_rd, in_ctrl};

    // in_ready depends only on state, never on out_ready
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    // OUT can be overwritten this cycle: empty or being consumed
    assign out_free = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_pay_d    = out_pay_q;
        skid_valid_d = skid_valid_q;
        skid_pay_d   = skid_pay_q;

        if (flush) begin
            out_valid_d                      = 1'b0;
            skid_valid_d                     = 1'b0;
            out_pay_d[CTRL_LSB +: CTRL_W]    = '0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // Older skid entry advances; a same-cycle input lands behind it
                out_valid_d  = 1'b1;
                out_pay_d    = skid_pay_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_pay_d = in_pay;
                end
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_pay_d   = in_pay;
            end else begin
                out_valid_d                   = 1'b0;
                out_pay_d[CTRL_LSB +: CTRL_W] = '0;
            end
        end else if (accept) begin
            // OUT stalled: park the new entry in the skid slot
            skid_valid_d = 1'b1;
            skid_pay_d   = in_pay;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_pay_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_pay_q   <= '0;
            stall_cnt_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_pay_q    <= out_pay_d;
            skid_valid_q <= skid_valid_d;
            skid_pay_q   <= skid_pay_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pc_added   = out_pay_q[PC_LSB +: DATA_W];
    assign out_zero       = out_pay_q[ZERO_LSB];
    assign out_alu_result = out_pay_q[ALU_LSB +: DATA_W];
    assign out_write_data = out_pay_q[WD_LSB +: DATA_W];
    assign out_rd         = out_pay_q[RD_LSB +: REG_ADDR_W];
    // Bubbles never carry control bits, regardless of register contents
    assign out_ctrl       = out_valid_q ? out_pay_q[CTRL_LSB +: CTRL_W] : '0;
    assign stall_cnt      = stall_cnt_q;

endmodule
